// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU pipeline-control types: FSM state encoding, register index width, control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

    localparam int REG_W = 5;
    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2,
        ST_STEP     = 2'd3
    } ctrl_state_t;

    // Pipeline register write enables and bubble-insert controls.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } pipe_ctl_t;

    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/debug inputs and pipeline-register controls between the datapath and pipeline_ctrl.
// Latency: wires only.
// Backpressure: none; dmem_ready is the only stall source from memory.
// master: datapath side (drives hazard/debug inputs); slave: pipeline_ctrl.
interface pipeline_ctrl_if;
    import pipeline_ctrl_pkg::*;

    logic        memread_ex;
    reg_idx_t    rd_ex;
    reg_idx_t    rs0_id;
    reg_idx_t    rs1_id;
    logic        use_rs0_id;
    logic        use_rs1_id;
    logic        branch_taken_ex;
    logic        dmem_req_mem;
    logic        dmem_ready;
    logic        dbg_halt;
    logic        dbg_step;

    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        memwb_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        memwb_flush;
    logic        halted;
    logic [31:0] stall_cnt;

    modport master (
        output memread_ex, rd_ex, rs0_id, rs1_id, use_rs0_id, use_rs1_id,
               branch_taken_ex, dmem_req_mem, dmem_ready, dbg_halt, dbg_step,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush, halted, stall_cnt
    );

    modport slave (
        input  memread_ex, rd_ex, rs0_id, rs1_id, use_rs0_id, use_rs1_id,
               branch_taken_ex, dmem_req_mem, dmem_ready, dbg_halt, dbg_step,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush, halted, stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard detect: ID source matches the destination of a load in EX.
// Latency: combinational.
// Backpressure: none.
// Ports: memread_ex, rd_ex, rs0_id/rs1_id, use_rs0_id/use_rs1_id in; load_use out.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic     memread_ex,
    input  reg_idx_t rd_ex,
    input  reg_idx_t rs0_id,
    input  reg_idx_t rs1_id,
    input  logic     use_rs0_id,
    input  logic     use_rs1_id,
    output logic     load_use
);
    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = memread_ex && (rd_ex != '0) &&
                      ((use_rs0_id && (rs0_id == rd_ex)) ||
                       (use_rs1_id && (rs1_id == rd_ex)));
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/debug controller: stalls, flushes, debug halt/step, stall-cycle counter.
// Latency: enables/flushes combinational in the triggering cycle; state change next cycle.
// Backpressure: a pending data-memory access (dmem_ready low) freezes the whole pipe.
// Ports: clk, rstn (async active-low), bus (pipeline_ctrl_if.slave).
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    pipeline_ctrl_if.slave  bus
);
    ctrl_state_t state;
    logic        step_pending;
    logic [31:0] stall_cnt_q;

    logic        load_use;
    logic        mem_stall;
    pipe_ctl_t   normal_ctl;
    pipe_ctl_t   ctl;
    logic        halted_c;

    load_use_detect u_load_use_detect (
        .memread_ex (bus.memread_ex),
        .rd_ex      (bus.rd_ex),
        .rs0_id     (bus.rs0_id),
        .rs1_id     (bus.rs1_id),
        .use_rs0_id (bus.use_rs0_id),
        .use_rs1_id (bus.use_rs1_id),
        .load_use   (load_use)
    );

    assign mem_stall = bus.dmem_req_mem && !bus.dmem_ready;

    // Normal decode, highest priority first. A taken branch squashes the
    // dependent instruction anyway, so it wins over the load-use bubble.
    always_comb begin
        normal_ctl = '{default: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0, memwb_flush: 1'b0};
        if (mem_stall) begin
            normal_ctl = '{default: 1'b0, memwb_flush: 1'b1};
        end else if (bus.branch_taken_ex) begin
            normal_ctl.ifid_flush = 1'b1;
            normal_ctl.idex_flush = 1'b1;
        end else if (load_use) begin
            normal_ctl.pc_en      = 1'b0;
            normal_ctl.ifid_en    = 1'b0;
            normal_ctl.idex_flush = 1'b1;
        end
    end

    // rstn gates the outputs directly so they drop in the same instant reset asserts.
    always_comb begin
        ctl      = '0;
        halted_c = 1'b0;
        if (rstn) begin
            unique case (state)
                ST_HALT: halted_c = 1'b1;
                ST_STEP: begin
                    ctl      = normal_ctl;
                    halted_c = 1'b1;
                end
                default: ctl = normal_ctl;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_RUN;
            step_pending <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    // The halt-boundary cycle is still decoded normally above.
                    if (mem_stall)         state <= ST_MEM_WAIT;
                    else if (bus.dbg_halt) state <= ST_HALT;
                end
                ST_MEM_WAIT: begin
                    if (bus.dmem_ready) begin
                        step_pending <= 1'b0;
                        if (step_pending || bus.dbg_halt) state <= ST_HALT;
                        else                              state <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (bus.dbg_step)      state <= ST_STEP;
                    else if (!bus.dbg_halt) state <= ST_RUN;
                end
                ST_STEP: begin
                    // A stepped instruction stuck on memory must still return to HALT.
                    if (mem_stall) begin
                        state        <= ST_MEM_WAIT;
                        step_pending <= 1'b1;
                    end else begin
                        state <= ST_HALT;
                    end
                end
                default: state <= ST_RUN;
            endcase

            if ((state != ST_HALT) && !ctl.pc_en && (stall_cnt_q != STALL_CNT_MAX))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.pc_en       = ctl.pc_en;
    assign bus.ifid_en     = ctl.ifid_en;
    assign bus.idex_en     = ctl.idex_en;
    assign bus.exmem_en    = ctl.exmem_en;
    assign bus.memwb_en    = ctl.memwb_en;
    assign bus.ifid_flush  = ctl.ifid_flush;
    assign bus.idex_flush  = ctl.idex_flush;
    assign bus.memwb_flush = ctl.memwb_flush;
    assign bus.halted      = halted_c;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule
